// File: rtl/pio_mem_bram_wide_pkg.sv
// pio_mem_bram_wide_pkg: shared PIO width, PIO FSM state type and clog2 helper
package pio_mem_bram_wide_pkg;
  localparam int PIO_NBITS = 32;
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_ISSUE, RD_DATA, ACK} pio_state_e;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/pio_mem_bram_wide_ram.sv
// ram_1r1w_bram: simple dual-port BRAM, registered read, read-before-write on address collision
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data.
module ram_1r1w_bram #(
  parameter int WIDTH = 72,
  parameter int DEPTH_NBITS = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [DEPTH_NBITS-1:0] waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   re,
  input  logic [DEPTH_NBITS-1:0] raddr,
  output logic [WIDTH-1:0]       rdata
);
  logic [WIDTH-1:0] mem [1 << DEPTH_NBITS];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/pio_mem_bram_wide.sv
// pio_mem_bram_wide: wide BRAM exposed as 32-bit PIO words plus a pipelined application read port
// Ports: clk, rst_n (async, active low); clk_div paces mem_ack; reg_addr/reg_din/reg_rd/reg_wr/reg_ms
//   PIO request, mem_ack/mem_rdata PIO response; app_mem_rd/app_mem_raddr application read,
//   app_mem_ack/app_mem_rdata its response one cycle later.
// Build option PIO_MEM_BRAM_PARITY_EN: even parity bit per entry, reported on mem_perr/app_mem_perr.
module pio_mem_bram_wide
  import pio_mem_bram_wide_pkg::*;
#(
  parameter int WIDTH = 72,
  parameter int DEPTH_NBITS = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_div,
  input  logic [31:0]            reg_addr,
  input  logic [31:0]            reg_din,
  input  logic                   reg_rd,
  input  logic                   reg_wr,
  input  logic                   reg_ms,
  input  logic                   app_mem_rd,
  input  logic [DEPTH_NBITS-1:0] app_mem_raddr,
  output logic                   mem_ack,
  output logic [31:0]            mem_rdata,
  output logic                   app_mem_ack,
`ifdef PIO_MEM_BRAM_PARITY_EN
  output logic                   mem_perr,
  output logic                   app_mem_perr,
`endif
  output logic [WIDTH-1:0]       app_mem_rdata
);
  localparam int NWORDS = (WIDTH + 31) / 32;
  localparam int WSEL_NBITS = NWORDS > 1 ? clog2(NWORDS) : 1;
  localparam int PW = NWORDS * PIO_NBITS;
  localparam logic [WSEL_NBITS:0] NW = (WSEL_NBITS + 1)'(NWORDS);
  localparam logic [WSEL_NBITS:0] LAST = NW - 1'b1;
`ifdef PIO_MEM_BRAM_PARITY_EN
  localparam int RW = WIDTH + 1;
`else
  localparam int RW = WIDTH;
`endif
  pio_state_e state, state_nx;
  logic [WSEL_NBITS-1:0] word_sel, req_wsel;
  logic [DEPTH_NBITS-1:0] entry, req_entry, snap_entry, ram_raddr;
  logic [PW-1:0] stage, wfull, snap_pad, ram_pad;
  logic [WIDTH-1:0] snap, wdata;
  logic [RW-1:0] ram_wdata, ram_rdata;
  logic strobe, wr, rd, hit, need_ram, rd_hit, commit, stg_wr, snap_vld, ram_we, ram_re;
  assign {entry, word_sel} = (DEPTH_NBITS + WSEL_NBITS)'(reg_addr >> 2);
  assign strobe = reg_ms & (reg_rd | reg_wr) & (state == IDLE);
  assign wr = strobe & reg_wr;
  assign rd = strobe & ~reg_wr;
  assign commit = wr & ({1'b0, word_sel} == LAST);
  assign stg_wr = wr & ({1'b0, word_sel} < LAST);
  assign hit = snap_vld & (snap_entry == entry) & (word_sel != '0);
  assign need_ram = rd & ({1'b0, word_sel} < NW) & ~hit;
  assign rd_hit = rd & ({1'b0, word_sel} < NW) & hit;
  always_comb begin
    wfull = stage;
    wfull[(NWORDS-1)*PIO_NBITS +: PIO_NBITS] = reg_din;
  end
  assign wdata = WIDTH'(wfull);
  assign snap_pad = PW'(snap);
  assign ram_pad = PW'(ram_rdata[WIDTH-1:0]);
  assign ram_we = commit;
  assign ram_re = app_mem_rd | (state == RD_ISSUE);
  assign ram_raddr = app_mem_rd ? app_mem_raddr : req_entry;
  assign app_mem_rdata = ram_rdata[WIDTH-1:0];
`ifdef PIO_MEM_BRAM_PARITY_EN
  logic ram_perr, snap_perr, rd_perr;
  assign ram_wdata = {^wdata, wdata};
  assign ram_perr = ^ram_rdata;
  assign app_mem_perr = app_mem_ack & ram_perr;
  assign mem_perr = mem_ack & rd_perr;
  always_ff @(posedge clk) begin
    if (strobe) rd_perr <= rd_hit & snap_perr;
    if (state == RD_DATA) begin
      rd_perr <= ram_perr;
      snap_perr <= ram_perr;
    end
  end
`else
  assign ram_wdata = wdata;
`endif
  // the application may reclaim the read port even in RD_ISSUE, so fall back to waiting
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = need_ram ? (app_mem_rd ? RD_WAIT : RD_ISSUE) : (strobe ? ACK : IDLE);
      RD_WAIT:  state_nx = app_mem_rd ? RD_WAIT : RD_ISSUE;
      RD_ISSUE: state_nx = app_mem_rd ? RD_WAIT : RD_DATA;
      RD_DATA:  state_nx = ACK;
      ACK:      state_nx = (clk_div && mem_ack) ? IDLE : ACK;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mem_ack <= 1'b0;
      app_mem_ack <= 1'b0;
      snap_vld <= 1'b0;
    end else begin
      state <= state_nx;
      app_mem_ack <= app_mem_rd;
      if (state == ACK && clk_div) mem_ack <= ~mem_ack;
      snap_vld <= (state == RD_DATA) | (snap_vld & ~(commit & (entry == snap_entry)));
    end
  end
  always_ff @(posedge clk) begin
    if (stg_wr) stage[word_sel*PIO_NBITS +: PIO_NBITS] <= reg_din;
    if (strobe) begin
      req_wsel <= word_sel;
      req_entry <= entry;
    end
    if (rd_hit) mem_rdata <= snap_pad[word_sel*PIO_NBITS +: PIO_NBITS];
    if (state == RD_DATA) begin
      mem_rdata <= ram_pad[req_wsel*PIO_NBITS +: PIO_NBITS];
      snap <= ram_rdata[WIDTH-1:0];
      snap_entry <= req_entry;
    end
  end
  ram_1r1w_bram #(.WIDTH(RW), .DEPTH_NBITS(DEPTH_NBITS)) u_ram (
    .clk(clk),
    .we(ram_we),
    .waddr(entry),
    .wdata(ram_wdata),
    .re(ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );
endmodule
